// File: rtl/memory_oam_dma_pkg.sv
// Shared constants and state encoding for the OAM DMA engine and its address decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package memory_oam_dma_pkg;

  // Decoded memory regions (inclusive limits)
  localparam logic [15:0] HRAM_BASE    = 16'hFF80;
  localparam logic [15:0] HRAM_LIMIT   = 16'hFFFE;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] OAM_LIMIT    = 16'hFE9F;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

  // Transfer geometry defaults
  localparam int DMA_LENGTH_DEF     = 160;
  localparam int SLOTS_PER_BYTE_DEF = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } dma_state_e;

endpackage

// File: rtl/memory_oam_dma_addr_decode.sv
// Purpose: map a 16-bit address onto active-low HRAM/OAM/external selects and flag the DMA register.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the outputs always follow i_address.
// Ports: i_address (in); o_hram_nsel, o_oam_nsel, o_ext_nsel (active-low selects); o_is_dma_reg (FF46 hit).
module memory_addr_decode
  import memory_oam_dma_pkg::*;
(
  input  logic [15:0] i_address,
  output logic        o_hram_nsel,
  output logic        o_oam_nsel,
  output logic        o_ext_nsel,
  output logic        o_is_dma_reg
);

  logic w_hram;
  logic w_oam;

  always_comb begin
    w_hram       = (i_address >= HRAM_BASE) && (i_address <= HRAM_LIMIT);
    w_oam        = (i_address >= OAM_BASE)  && (i_address <= OAM_LIMIT);
    o_is_dma_reg = (i_address == DMA_REG_ADDR);
    o_hram_nsel  = !w_hram;
    o_oam_nsel   = !w_oam;
    // The DMA register lives inside this block, so it selects nothing downstream.
    o_ext_nsel   = w_hram || w_oam || o_is_dma_reg;
  end

endmodule

// File: rtl/memory_oam_dma.sv
// Purpose: OAM DMA engine; copies DMA_LENGTH bytes from {src,00} to FE00 while arbitrating the CPU bus.
// Latency: one byte every SLOTS_PER_BYTE cycles; transfer starts the cycle after the FF46 write.
// Backpressure: cpu_wait stalls CPU HRAM accesses during the DMA read/write slots; other CPU accesses are never stalled.
// Ports: clock/reset; CPU side cpu_address, cpu_wdata, cpu_rdata, cpu_nread, cpu_nwrite, cpu_wait;
//        bus side address_bus, data_bus (inout), nread, nwrite, hram_nsel, oam_nsel, ext_nsel; status dma_active.
module memory_oam_dma
  import memory_oam_dma_pkg::*;
#(
  parameter int DMA_LENGTH     = DMA_LENGTH_DEF,
  parameter int SLOTS_PER_BYTE = SLOTS_PER_BYTE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        cpu_nread,
  input  logic        cpu_nwrite,
  output logic        cpu_wait,
  output logic [15:0] address_bus,
  inout  wire  [7:0]  data_bus,
  output logic        nread,
  output logic        nwrite,
  output logic        hram_nsel,
  output logic        oam_nsel,
  output logic        ext_nsel,
  output logic        dma_active
);

  localparam int              SLOT_W     = (SLOTS_PER_BYTE > 1) ? $clog2(SLOTS_PER_BYTE) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_PER_BYTE - 1);
  localparam logic [SLOT_W-1:0] SLOT_WR   = SLOT_W'(1);
  localparam logic [7:0]      LAST_INDEX = 8'(DMA_LENGTH - 1);

  dma_state_e        r_state, w_state_nxt;
  logic [7:0]        r_index, w_index_nxt;
  logic [SLOT_W-1:0] r_slot,  w_slot_nxt;
  logic [7:0]        r_src,   w_src_nxt;
  logic [7:0]        r_byte,  w_byte_nxt;

  logic        w_cpu_rd, w_cpu_wr;
  logic        w_cpu_hram_nsel, w_cpu_oam_nsel, w_cpu_ext_nsel, w_cpu_is_reg;
  logic [15:0] w_dma_addr;
  logic        w_dma_hram_nsel, w_dma_oam_nsel, w_dma_ext_nsel, w_dma_is_reg;
  logic        w_bus_drive;
  logic [7:0]  w_bus_dat;

  assign w_cpu_rd   = !cpu_nread;
  assign w_cpu_wr   = !cpu_nwrite;
  assign w_dma_addr = {r_src, r_index};

  memory_addr_decode u_cpu_dec (
    .i_address    (cpu_address),
    .o_hram_nsel  (w_cpu_hram_nsel),
    .o_oam_nsel   (w_cpu_oam_nsel),
    .o_ext_nsel   (w_cpu_ext_nsel),
    .o_is_dma_reg (w_cpu_is_reg)
  );

  memory_addr_decode u_dma_dec (
    .i_address    (w_dma_addr),
    .o_hram_nsel  (w_dma_hram_nsel),
    .o_oam_nsel   (w_dma_oam_nsel),
    .o_ext_nsel   (w_dma_ext_nsel),
    .o_is_dma_reg (w_dma_is_reg)
  );

  assign data_bus   = w_bus_drive ? w_bus_dat : 8'hzz;
  assign dma_active = (r_state == ACTIVE) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_index <= '0;
      r_slot  <= '0;
      r_src   <= '0;
      r_byte  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_slot  <= w_slot_nxt;
      r_src   <= w_src_nxt;
      r_byte  <= w_byte_nxt;
    end
  end

  // Next state: an FF46 write wins over everything and (re)starts the copy.
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_slot_nxt  = r_slot;
    w_src_nxt   = r_src;
    w_byte_nxt  = r_byte;
    if (w_cpu_wr && w_cpu_is_reg) begin
      w_src_nxt   = cpu_wdata;
      w_state_nxt = ACTIVE;
      w_index_nxt = '0;
      w_slot_nxt  = '0;
    end else if (r_state == ACTIVE) begin
      if (r_slot == '0) begin
        // FF46 is internal, so a DMA sweeping it copies the register rather than the floating bus.
        w_byte_nxt = w_dma_is_reg ? r_src : data_bus;
      end
      if (r_slot == LAST_SLOT) begin
        w_slot_nxt = '0;
        if (r_index == LAST_INDEX) begin
          w_state_nxt = IDLE;
          w_index_nxt = '0;
        end else begin
          w_index_nxt = r_index + 8'd1;
        end
      end else begin
        w_slot_nxt = r_slot + SLOT_W'(1);
      end
    end
  end

  // Bus and CPU-side outputs.
  always_comb begin
    address_bus = cpu_address;
    nread       = 1'b1;
    nwrite      = 1'b1;
    hram_nsel   = 1'b1;
    oam_nsel    = 1'b1;
    ext_nsel    = 1'b1;
    cpu_rdata   = data_bus;
    cpu_wait    = 1'b0;
    w_bus_drive = 1'b0;
    w_bus_dat   = cpu_wdata;
    if (reset) begin
      // Hold everything inactive while in reset.
    end else if (r_state == IDLE) begin
      if (w_cpu_is_reg) begin
        cpu_rdata = r_src;
      end else begin
        nread       = cpu_nread;
        nwrite      = cpu_nwrite;
        hram_nsel   = w_cpu_hram_nsel;
        oam_nsel    = w_cpu_oam_nsel;
        ext_nsel    = w_cpu_ext_nsel;
        w_bus_drive = w_cpu_wr;
      end
    end else begin
      if (r_slot == '0) begin
        address_bus = w_dma_addr;
        nread       = 1'b0;
        hram_nsel   = w_dma_hram_nsel;
        oam_nsel    = w_dma_oam_nsel;
        ext_nsel    = w_dma_ext_nsel;
      end else if (r_slot == SLOT_WR) begin
        address_bus = OAM_BASE + {8'h00, r_index};
        nwrite      = 1'b0;
        oam_nsel    = 1'b0;
        w_bus_drive = 1'b1;
        w_bus_dat   = r_byte;
      end else if (!w_cpu_hram_nsel) begin
        nread       = cpu_nread;
        nwrite      = cpu_nwrite;
        hram_nsel   = 1'b0;
        w_bus_drive = w_cpu_wr;
      end
      // CPU side: HRAM stalls in the DMA slots, everything else outside FF46 is blocked.
      if (w_cpu_is_reg) begin
        cpu_rdata = r_src;
      end else if (!w_cpu_hram_nsel) begin
        cpu_wait = (r_slot == '0 || r_slot == SLOT_WR) && (w_cpu_rd || w_cpu_wr);
      end else begin
        cpu_rdata = 8'hFF;
      end
    end
  end

endmodule

// File: doc/memory_oam_dma.md
MEMORY_OAM_DMA -- requirements
Module: memory_oam_dma

Interface
REQ-001 Parameter DMA_LENGTH, default 160: bytes copied per transfer.
REQ-002 Parameter SLOTS_PER_BYTE, default 4: clock cycles per copied byte (slot 0 read, slot 1 write, slots 2-3 CPU).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 cpu_address  input  16  CPU address.
REQ-006 cpu_wdata  input  8  CPU write data.
REQ-007 cpu_rdata  output  8  CPU read data.
REQ-008 cpu_nread / cpu_nwrite  input  1 each  active-low CPU strobes; never both low.
REQ-009 cpu_wait  output  1  high: CPU access not serviced this cycle; CPU holds request.
REQ-010 address_bus  output  16  downstream address.
REQ-011 data_bus  inout  8  downstream data; driven by this block only when nwrite is low, else Z.
REQ-012 nread / nwrite  output  1 each  active-low downstream strobes.
REQ-013 hram_nsel / oam_nsel / ext_nsel  output  1 each  active-low selects: FF80-FFFE, FE00-FE9F, all other addresses except FF46.
REQ-014 dma_active  output  1  high while a transfer is in progress.

Function
REQ-015 Idle: address_bus=cpu_address, nread/nwrite follow CPU strobes, selects decoded from cpu_address, cpu_rdata=data_bus, cpu_wait=0.
REQ-016 CPU access to FF46 never reaches the bus (all selects high); reads return the DMA source register, writes load it.
REQ-017 Write to FF46 sampled at edge N: dma_active=1 from cycle N+1, byte index 0, slot 0.
REQ-018 Slot 0: address_bus={src,index[7:0]}, nread=0, select decoded from that address; data latched at end of slot.
REQ-019 Slot 1: address_bus=FE00+index, nwrite=0, oam_nsel=0, data_bus driven with latched byte.
REQ-020 Slots 2-3: CPU access to FF80-FFFE passes through as in idle; otherwise bus strobes and selects inactive.
REQ-021 During DMA, CPU HRAM access in slot 0/1: cpu_wait=1, nothing issued to the bus.
REQ-022 During DMA, CPU non-HRAM, non-FF46 access: cpu_wait=0, reads return 8'hFF, writes dropped.
REQ-023 After slot 3 of index DMA_LENGTH-1, dma_active=0 next cycle; return to idle.
REQ-024 FF46 write during DMA (any slot) reloads source and restarts at index 0, slot 0 next cycle.
REQ-025 Source byte used verbatim; index counter 8-bit, never exceeds DMA_LENGTH-1.
REQ-026 Total transfer time: exactly DMA_LENGTH*SLOTS_PER_BYTE cycles with dma_active high.

Reset
REQ-027 On reset: state idle, dma_active=0, index=0, slot=0, source register=8'h00, latched byte=8'h00.
REQ-028 Reset mid-transfer aborts immediately; next cycle is idle pass-through with no OAM write issued.
REQ-029 During reset cycle: nread=nwrite=1, all selects high, data_bus Z, cpu_wait=0.

Structure
REQ-030 Shared package holds address constants (HRAM, OAM, FF46 bases/limits), DMA_LENGTH and SLOTS_PER_BYTE defaults, and state encoding IDLE/ACTIVE.
REQ-031 Address decode is one sub-module, memory_addr_decode (address in, three active-low selects plus is_dma_reg out), used for both CPU and DMA addresses.

Verification
REQ-032 Idle CPU write 8'h5A to FF90 -> hram_nsel=0, nwrite=0, data_bus=8'h5A same cycle; readback returns 8'h5A.
REQ-033 Source C000-C09F preloaded i^8'h3C; write 8'hC0 to FF46 -> OAM FE00+i holds i^8'h3C; dma_active high exactly 640 cycles.
REQ-034 During DMA, CPU read FF80 in slot 0 -> cpu_wait=1 for 2 cycles, data returned in slot 2; read C000 -> 8'hFF, cpu_wait=0.
REQ-035 Write 8'hC1 to FF46 at index 50 -> restart at index 0, OAM gets C100 data, total active 640 cycles after restart.
REQ-036 Reset asserted at index 80 slot 0 -> no further OAM writes, dma_active=0, FF46 reads 8'h00.
REQ-037 Read FF46 after writing 8'hD0 -> 8'hD0 returned, no select asserted on the bus.
